mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single word-addressed program/data memory between the RISC-V core's instruction-fetch port and its load/store port. Each requester uses a valid/ready request channel and a valid/ready response channel. The arbiter grants at most one memory access per cycle against the memory's combinational read path and registers the response. It sits between the core and the memory macro, so the core never drives the memory directly.

## Interface
- ADDR_W, 32, byte address width of both requesters and of the memory port
- DATA_W, 32, data word width; byte enables are DATA_W/8 bits
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid / i_req_ready  in / out  1  fetch request handshake
- i_req_addr  in  ADDR_W  fetch byte address
- i_rsp_valid / i_rsp_ready  out / in  1  fetch response handshake
- i_rsp_data  out  DATA_W  fetched word
- i_rsp_err  out  1  misaligned fetch; no memory access was made
- d_req_valid / d_req_ready  in / out  1  data request handshake
- d_req_addr  in  ADDR_W  data byte address
- d_req_we  in  1  1 = store, 0 = load
- d_req_wdata  in  DATA_W  store data
- d_req_be  in  DATA_W/8  store byte enables
- d_rsp_valid / d_rsp_ready  out / in  1  data response handshake
- d_rsp_data  out  DATA_W  load word; 0 for stores
- d_rsp_err  out  1  misaligned access; no memory access was made
- mem_addr  out  ADDR_W-2  word index, equal to the granted address[ADDR_W-1:2]
- mem_we / mem_be / mem_wdata  out  1 / DATA_W/8 / DATA_W  write strobe, byte enables, write data
- mem_rdata  in  DATA_W  combinational read data for mem_addr

## Operation
- Each port has one response slot, so each port has at most one transaction outstanding.
- A port is eligible when its req_valid=1 and its slot is empty or is being drained this cycle (rsp_valid & rsp_ready).
- Priority when both ports are eligible: data wins by default. Fetch wins on the next conflict after a data grant only when the round-robin macro is enabled (see Configuration).
- req_ready is asserted for the granted port only, and only when that port is eligible. Grant occurs on the cycle with req_valid & req_ready.
- On a granted cycle:
  - mem_addr is driven from the granted request.
  - mem_we is 1 only for a data store with address[1:0]=0.
  - The slot captures mem_rdata (loads and fetches), 0 (stores), and err=(address[1:0]!=0).
- Misaligned requests are granted normally but never assert mem_we. Their slot data is 0 and err=1.
- When nothing is granted: mem_we=0 and mem_be=0. mem_addr and mem_wdata hold their last values.
- Per-port slot states:
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready without a new grant.
  - FULL→FULL on rsp_ready with a same-cycle grant. The new data overwrites the slot.
- rsp_valid, rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Response latency: rsp_valid rises on the cycle after the grant (1 cycle).
- Throughput: one grant per cycle total. A single port sustains 1/cycle while its rsp_ready is held at 1.
- Reset:
  - Both slots EMPTY. All rsp_valid=0, rsp_data=0, rsp_err=0.
  - mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer set to "data".
- Reset asserted mid-transaction drops both slots. No response is emitted after reset release.
- Simultaneous drain and regrant on the same port counts as a legal 1/cycle stream, not as a conflict.
- req_ready is a combinational function of req_valid, slot state, rsp_ready and the pointer. rsp_* outputs are registered only.

## Configuration
- MEM_ARB_RR_EN defined: a 1-bit pointer toggles to the other port after every contested grant. Fetch and data then alternate under sustained conflict, and neither port can starve.
- MEM_ARB_RR_EN undefined: fixed priority, data always wins. The pointer flop is not built, and fetch stalls for as long as data requests remain eligible.

## Structure
- Shared package mem_arb_pkg:
  - slot state enum {SLOT_EMPTY, SLOT_FULL}
  - port id constants PORT_I=0, PORT_D=1
  - word-alignment mask constant
- Sub-module mem_arb_slot: the per-port response register with its EMPTY/FULL state and drain/capture logic. It is instantiated twice.

## Test plan
- Fetch only, addr 0x0, 0x4, 0x8 back-to-back with i_rsp_ready=1 → three responses on consecutive cycles, data equal to mem[0], mem[1], mem[2], err=0.
- Store 0xDEADBEEF, be=4'b0011, to 0x10, then load 0x10 → single mem_we pulse with mem_addr=4; d_rsp_data=0 for the store; the load then returns the updated word.
- Both ports valid for 4 cycles with MEM_ARB_RR_EN → grants D, I, D, I. Without the macro → D, D, D, D, and i_req_ready stays 0.
- d_req_addr=0x6 store → d_rsp_err=1, d_rsp_data=0, mem_we never asserted.
- i_rsp_ready=0 for 3 cycles while the fetch slot is FULL → i_req_ready=0 and i_rsp_* stable. On release, the next fetch is granted on the same cycle as the drain.
- rst pulsed while both slots are FULL → both rsp_valid=0 asynchronously, and no stale response appears after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   slot_state_e    : per-port response slot state
//   PORT_I / PORT_D : port ids, also the encoding of the round-robin pointer
//   WORD_ALIGN_MASK : low address bits that must be zero for a word access
package mem_arb_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: all core-side request/response channels plus the memory
// macro port of the arbiter.
//   slave  : arbiter view (takes requests, drives responses and memory port)
//   master : environment view (core requesters + memory macro)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_W-1:0]     i_req_addr;
    logic                  i_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_W-1:0]     i_rsp_data;
    logic                  i_rsp_err;
    // data port
    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_W-1:0]     d_req_addr;
    logic                  d_req_we;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_be;
    logic                  d_rsp_valid;
    logic                  d_rsp_ready;
    logic [DATA_W-1:0]     d_rsp_data;
    logic                  d_rsp_err;
    // memory macro
    logic [ADDR_W-3:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be, d_rsp_ready,
        input  mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_addr, mem_we, mem_be, mem_wdata
    );

    modport master (
        output i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be, d_rsp_ready,
        output mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_addr, mem_we, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one-entry registered response slot for one arbiter port.
//   clk, rst     : clock, async active-high reset (drops the slot)
//   i_cap        : port granted this cycle; load i_cap_data / i_cap_err
//   i_rsp_ready  : consumer accepts the response this cycle
//   o_free       : slot can take a new grant this cycle (empty or draining)
//   o_rsp_*      : registered response channel
module mem_arb_slot
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cap,
    input  logic [DATA_W-1:0] i_cap_data,
    input  logic              i_cap_err,
    input  logic              i_rsp_ready,
    output logic              o_free,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    slot_state_e       r_state;
    slot_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SLOT_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // A capture wins over a drain: drain + regrant in one cycle stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        if (i_cap)
            w_state_nxt = SLOT_FULL;
        else if (r_state == SLOT_FULL && i_rsp_ready)
            w_state_nxt = SLOT_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (i_cap) begin
            r_data <= i_cap_data;
            r_err  <= i_cap_err;
        end
    end

    assign o_free      = (r_state == SLOT_EMPTY) || i_rsp_ready;
    assign o_rsp_valid = (r_state == SLOT_FULL);
    assign o_rsp_data  = r_data;
    assign o_rsp_err   = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between the fetch (i_*) and
// load/store (d_*) ports of the core. At most one access per cycle against
// the memory's combinational read path; responses are registered in a
// one-entry slot per port (1-cycle latency, 1/cycle per port).
//   clk, rst : clock, async active-high reset
//   bus      : mem_arbiter_if.slave - both request/response channels and
//              the memory macro port (mem_addr is a word index)
// Build option: MEM_ARB_RR_EN - round-robin between ports on conflict;
// undefined gives fixed data-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int BE_W = DATA_W / 8;

    logic              w_i_free, w_d_free;
    logic              w_i_elig, w_d_elig;
    logic              w_gnt_i, w_gnt_d, w_any;
    logic [ADDR_W-1:0] w_addr;
    logic              w_mis, w_store;
    logic [DATA_W-1:0] w_cap_data;
    logic [ADDR_W-3:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Nothing is granted while reset is held, so the memory port shows its
    // reset values even if requesters are already asserting valid.
    assign w_i_elig = bus.i_req_valid & w_i_free & ~rst;
    assign w_d_elig = bus.d_req_valid & w_d_free & ~rst;

`ifdef MEM_ARB_RR_EN
    logic r_ptr;

    // Pointer names the port that wins the next conflict; it flips to the
    // loser after each contested grant so neither port starves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= PORT_D;
        else if (w_i_elig && w_d_elig)
            r_ptr <= w_gnt_d ? PORT_I : PORT_D;
    end

    assign w_gnt_d = w_d_elig & (~w_i_elig | (r_ptr == PORT_D));
`else
    assign w_gnt_d = w_d_elig;
`endif

    assign w_gnt_i = w_i_elig & ~w_gnt_d;
    assign w_any   = w_gnt_i | w_gnt_d;

    assign bus.i_req_ready = w_gnt_i;
    assign bus.d_req_ready = w_gnt_d;

    assign w_addr  = w_gnt_d ? bus.d_req_addr : bus.i_req_addr;
    assign w_mis   = is_misaligned(w_addr[1:0]);
    assign w_store = w_gnt_d & bus.d_req_we;

    // Misaligned accesses still take the grant but never touch memory.
    assign bus.mem_we = w_store & ~w_mis;
    assign bus.mem_be = bus.mem_we ? bus.d_req_be : {BE_W{1'b0}};

    // Address and write data hold their last driven value between grants.
    assign w_mem_addr  = w_any   ? w_addr[ADDR_W-1:2] : r_mem_addr;
    assign w_mem_wdata = w_gnt_d ? bus.d_req_wdata    : r_mem_wdata;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    // Only one port is granted per cycle, so both slots share one capture word.
    assign w_cap_data = (w_mis | w_store) ? {DATA_W{1'b0}} : bus.mem_rdata;

    mem_arb_slot #(.DATA_W(DATA_W)) u_slot_i (
        .clk         (clk),
        .rst         (rst),
        .i_cap       (w_gnt_i),
        .i_cap_data  (w_cap_data),
        .i_cap_err   (w_mis),
        .i_rsp_ready (bus.i_rsp_ready),
        .o_free      (w_i_free),
        .o_rsp_valid (bus.i_rsp_valid),
        .o_rsp_data  (bus.i_rsp_data),
        .o_rsp_err   (bus.i_rsp_err)
    );

    mem_arb_slot #(.DATA_W(DATA_W)) u_slot_d (
        .clk         (clk),
        .rst         (rst),
        .i_cap       (w_gnt_d),
        .i_cap_data  (w_cap_data),
        .i_cap_err   (w_mis),
        .i_rsp_ready (bus.d_rsp_ready),
        .o_free      (w_d_free),
        .o_rsp_valid (bus.d_rsp_valid),
        .o_rsp_data  (bus.d_rsp_data),
        .o_rsp_err   (bus.d_rsp_err)
    );

endmodule
